// File: rtl/ahb_os_pkg.sv
// Shared AHB encodings and burst helpers for the bus-matrix output stages.
package ahb_os_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    localparam int BEAT_W = 4;
    localparam int GCNT_W = 16;

    // Beats still to come after the NONSEQ of a fixed-length burst.
    function automatic logic [BEAT_W-1:0] burst_beats(input logic [2:0] hburst);
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  burst_beats = 4'd3;
            HBURST_WRAP8,  HBURST_INCR8:  burst_beats = 4'd7;
            HBURST_WRAP16, HBURST_INCR16: burst_beats = 4'd15;
            default:                      burst_beats = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_output_stage_rr_if.sv
// Bus bundle between the input stages, the output stage and the shared slave.
// slave: view taken by the output stage; master: view of whatever drives it.
interface ahb_output_stage_rr_if #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
);
    logic [NUM_PORTS-1:0]        sel_op;
    logic [NUM_PORTS*ADDR_W-1:0] addr_op;
    logic [NUM_PORTS*2-1:0]      trans_op;
    logic [NUM_PORTS-1:0]        write_op;
    logic [NUM_PORTS*3-1:0]      size_op;
    logic [NUM_PORTS*3-1:0]      burst_op;
    logic [NUM_PORTS*4-1:0]      prot_op;
    logic [NUM_PORTS*4-1:0]      master_op;
    logic [NUM_PORTS-1:0]        mastlock_op;
    logic [NUM_PORTS*DATA_W-1:0] wdata_op;
    logic [NUM_PORTS-1:0]        held_tran_op;
    logic                        HREADYOUTM;

    logic [NUM_PORTS-1:0]        active_op;
    logic                        HSELM;
    logic [ADDR_W-1:0]           HADDRM;
    logic [1:0]                  HTRANSM;
    logic                        HWRITEM;
    logic [2:0]                  HSIZEM;
    logic [2:0]                  HBURSTM;
    logic [3:0]                  HPROTM;
    logic [3:0]                  HMASTERM;
    logic                        HMASTLOCKM;
    logic                        HREADYMUXM;
    logic [DATA_W-1:0]           HWDATAM;

    modport slave (
        input  sel_op, addr_op, trans_op, write_op, size_op, burst_op, prot_op,
               master_op, mastlock_op, wdata_op, held_tran_op, HREADYOUTM,
        output active_op, HSELM, HADDRM, HTRANSM, HWRITEM, HSIZEM, HBURSTM,
               HPROTM, HMASTERM, HMASTLOCKM, HREADYMUXM, HWDATAM
    );

    modport master (
        output sel_op, addr_op, trans_op, write_op, size_op, burst_op, prot_op,
               master_op, mastlock_op, wdata_op, held_tran_op, HREADYOUTM,
        input  active_op, HSELM, HADDRM, HTRANSM, HWRITEM, HSIZEM, HBURSTM,
               HPROTM, HMASTERM, HMASTLOCKM, HREADYMUXM, HWDATAM
    );

endinterface

// File: rtl/ahb_os_rr_arbiter.sv
// Round-robin arbiter with external hold; reusable by any output stage.
module ahb_os_rr_arbiter #(
    parameter  int NUM_PORTS = 4,
    localparam int PORT_W    = $clog2(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 advance,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 hold,
    output logic [PORT_W-1:0]    grant_port,
    output logic                 no_port
);
    logic [PORT_W-1:0] grant_port_q, grant_port_d;
    logic [PORT_W-1:0] last_port_q, last_port_d;
    logic              no_port_q, no_port_d;
    logic [PORT_W-1:0] winner;
    logic              found;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        grant_port_d = grant_port_q;
        last_port_d  = last_port_q;
        no_port_d    = no_port_q;
        winner       = '0;
        found        = 1'b0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            int idx;
            idx = (int'(last_port_q) + i) % NUM_PORTS;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = PORT_W'(idx);
            end
        end
        if (!hold) begin
            if (found) begin
                grant_port_d = winner;
                last_port_d  = winner;
                no_port_d    = 1'b0;
            end else begin
                no_port_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it is just the first branch of the clocked block.
        if (rst) begin
            // NOTE: state flops use non-blocking assignments so all update together.
            grant_port_q <= '0;
            last_port_q  <= PORT_W'(NUM_PORTS - 1);
            no_port_q    <= 1'b1;
        end else if (advance) begin
            grant_port_q <= grant_port_d;
            last_port_q  <= last_port_d;
            no_port_q    <= no_port_d;
        end
    end

    assign grant_port = grant_port_q;
    assign no_port    = no_port_q;

endmodule

// File: rtl/ahb_output_stage_rr.sv
// AHB-Lite bus-matrix output stage: round-robin muxes NUM_PORTS input stages onto one slave.
// Optional per-port accepted-NONSEQ counters are built when AHB_OS_GRANT_CNT_EN is defined.
module ahb_output_stage_rr
    import ahb_os_pkg::*;
#(
    parameter  int NUM_PORTS = 4,
    parameter  int ADDR_W    = 32,
    parameter  int DATA_W    = 32,
    localparam int PORT_W    = $clog2(NUM_PORTS)
) (
    input  logic                        HCLK,
    input  logic                        HRESET,
`ifdef AHB_OS_GRANT_CNT_EN
    output logic [NUM_PORTS*GCNT_W-1:0] grant_cnt,
`endif
    ahb_output_stage_rr_if.slave        bus
);
    logic [NUM_PORTS-1:0] req;
    logic [PORT_W-1:0]    grant_port;
    logic                 no_port;
    logic                 hold;
    logic                 hlock_arb;
    logic                 hready_mux;
    htrans_e              htrans_m;
    logic [BEAT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic                 hsel_lock_q, hsel_lock_d;
    logic [PORT_W-1:0]    data_port_q, data_port_d;
    logic                 slave_sel_q, slave_sel_d;

    assign req = bus.held_tran_op & bus.sel_op;

    ahb_os_rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
        .clk        (HCLK),
        .rst        (HRESET),
        .advance    (hready_mux),
        .req        (req),
        .hold       (hold),
        .grant_port (grant_port),
        .no_port    (no_port)
    );

    always_comb begin
        bus.active_op  = '0;
        bus.HSELM      = 1'b0;
        bus.HADDRM     = '0;
        bus.HTRANSM    = '0;
        bus.HWRITEM    = 1'b0;
        bus.HSIZEM     = '0;
        bus.HBURSTM    = '0;
        bus.HPROTM     = '0;
        bus.HMASTERM   = '0;
        bus.HMASTLOCKM = 1'b0;
        if (!no_port) begin
            bus.active_op[grant_port] = 1'b1;
            bus.HSELM      = bus.sel_op[grant_port];
            bus.HADDRM     = bus.addr_op[int'(grant_port) * ADDR_W +: ADDR_W];
            bus.HTRANSM    = bus.trans_op[int'(grant_port) * 2 +: 2];
            bus.HWRITEM    = bus.write_op[grant_port];
            bus.HSIZEM     = bus.size_op[int'(grant_port) * 3 +: 3];
            bus.HBURSTM    = bus.burst_op[int'(grant_port) * 3 +: 3];
            bus.HPROTM     = bus.prot_op[int'(grant_port) * 4 +: 4];
            bus.HMASTERM   = bus.master_op[int'(grant_port) * 4 +: 4];
            bus.HMASTLOCKM = bus.mastlock_op[grant_port];
        end
    end

    assign hready_mux     = slave_sel_q ? bus.HREADYOUTM : 1'b1;
    assign bus.HREADYMUXM = hready_mux;
    assign bus.HWDATAM    = bus.wdata_op[int'(data_port_q) * DATA_W +: DATA_W];
    assign htrans_m       = htrans_e'(bus.HTRANSM);

    // Hold keeps the grant through locked sequences (even with HSEL dropped) and fixed bursts.
    always_comb begin
        hlock_arb   = bus.HMASTLOCKM & (hsel_lock_q | bus.HSELM);
        hsel_lock_d = hsel_lock_q;
        if (bus.HSELM && bus.HTRANSM[1] && bus.HMASTLOCKM) hsel_lock_d = 1'b1;
        else if (!bus.HMASTLOCKM)                          hsel_lock_d = 1'b0;

        beat_cnt_d = '0;
        if (bus.HSELM && htrans_m == HTRANS_NONSEQ)
            beat_cnt_d = burst_beats(bus.HBURSTM);
        else if (bus.HSELM && htrans_m == HTRANS_SEQ && beat_cnt_q != '0)
            beat_cnt_d = beat_cnt_q - 1'b1;
        else if (htrans_m == HTRANS_BUSY)
            beat_cnt_d = beat_cnt_q;

        hold        = hlock_arb | (beat_cnt_d != '0) | (htrans_m == HTRANS_BUSY);
        data_port_d = grant_port;
        slave_sel_d = bus.HSELM;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            beat_cnt_q  <= '0;
            hsel_lock_q <= 1'b0;
            data_port_q <= '0;
            slave_sel_q <= 1'b0;
        end else if (hready_mux) begin
            beat_cnt_q  <= beat_cnt_d;
            hsel_lock_q <= hsel_lock_d;
            data_port_q <= data_port_d;
            slave_sel_q <= slave_sel_d;
        end
    end

`ifdef AHB_OS_GRANT_CNT_EN
    logic [NUM_PORTS-1:0][GCNT_W-1:0] gcnt_q, gcnt_d;

    always_comb begin
        gcnt_d = gcnt_q;
        if (bus.HSELM && htrans_m == HTRANS_NONSEQ && gcnt_q[grant_port] != '1)
            gcnt_d[grant_port] = gcnt_q[grant_port] + 1'b1;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET)          gcnt_q <= '0;
        else if (hready_mux) gcnt_q <= gcnt_d;
    end

    assign grant_cnt = gcnt_q;
`endif

endmodule
